// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational 8-bit ALU: buffers commands, drives the ALU for a
// settle window, samples result and flags, and returns them with the command tag.
module alu_cmd_sequencer #(
    parameter int SETTLE = 2,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_oe,
    input  logic [7:0]       alu_y,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    input  logic             alu_greater,
    input  logic             alu_is_eq,
    input  logic             alu_less,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
    } state_t;

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [TAG_W-1:0] r_cur_tag;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [1:0]       r_alu_op;
    logic             r_alu_oe;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_y;
    logic [4:0]       r_rsp_flags;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [15:0]      r_op_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    cmd_t w_head;

    assign w_full  = (r_occ == OCC_W'(DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_push  = cmd_valid & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];
    // A pop happens only when the FSM is ready to start a new command this edge.
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready));

    // NOTE: buffer storage has no reset; the pointers and occupancy define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_tag   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
            r_rsp_tag   <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_a   <= w_head.a;
                        r_alu_b   <= w_head.b;
                        r_alu_op  <= w_head.op;
                        r_cur_tag <= w_head.tag;
                        r_alu_oe  <= 1'b1;
                        r_cnt     <= 4'(SETTLE - 1);
                        r_state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_y     <= alu_y;
                        r_rsp_flags <= {alu_overflow, alu_parity, alu_greater, alu_is_eq, alu_less};
                        r_rsp_tag   <= r_cur_tag;
                        r_rsp_valid <= 1'b1;
                        r_alu_oe    <= 1'b0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_op_count  <= r_op_count + 16'd1;
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a   <= w_head.a;
                            r_alu_b   <= w_head.b;
                            r_alu_op  <= w_head.op;
                            r_cur_tag <= w_head.tag;
                            r_alu_oe  <= 1'b1;
                            r_cnt     <= 4'(SETTLE - 1);
                            r_state   <= S_DRIVE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = ~w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_oe    = r_alu_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_flags = r_rsp_flags;
    assign rsp_tag   = r_rsp_tag;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a stub ALU, a reference model of the expected
// responses, a decoupled monitor, directed edge cases and a randomized traffic phase.
module tb_alu_cmd_sequencer;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [1:0]       cmd_op = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [1:0]       alu_op;
    logic             alu_oe;
    logic [7:0]       alu_y;
    logic             alu_parity;
    logic             alu_overflow;
    logic             alu_greater;
    logic             alu_is_eq;
    logic             alu_less;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_y;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [15:0]      op_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.SETTLE(SETTLE), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_oe(alu_oe),
        .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .alu_greater(alu_greater), .alu_is_eq(alu_is_eq), .alu_less(alu_less),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy), .op_count(op_count)
    );

    // Stub ALU: add with carry out, parity of the sum, unsigned compare of the operands.
    always_comb begin
        {alu_overflow, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_parity  = ^alu_y;
        alu_greater = alu_a > alu_b;
        alu_is_eq   = alu_a == alu_b;
        alu_less    = alu_a < alu_b;
    end

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [7:0]       y;
        logic [4:0]       flags;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_count = '0;
    bit          mon_en = 1'b0;
    bit          rand_ready_en = 1'b0;
    bit          ready_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] op, input logic [TAG_W-1:0] tag);
        exp_t e;
        int   sum;
        int   ones;
        sum  = int'(a) + int'(b);
        e.a  = a;
        e.b  = b;
        e.op = op;
        e.tag = tag;
        e.y  = 8'(sum % 256);
        ones = $countones(e.y);
        e.flags = {sum > 255, (ones % 2) == 1, int'(a) > int'(b), int'(a) == int'(b), int'(a) < int'(b)};
        return e;
    endfunction

    // Consumer readiness is owned by this one process: random or a fixed level.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_ready_en ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares the driven ALU inputs and every presented response against the queue head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("op_count", op_count, exp_count);
            if (alu_oe) begin
                if (sb_q.size() == 0) begin
                    check("drive_unexpected", alu_oe, 0);
                end else begin
                    check("alu_a", alu_a, sb_q[0].a);
                    check("alu_b", alu_b, sb_q[0].b);
                    check("alu_op", alu_op, sb_q[0].op);
                end
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    check("rsp_y", rsp_y, sb_q[0].y);
                    check("rsp_flags", rsp_flags, sb_q[0].flags);
                    check("rsp_tag", rsp_tag, sb_q[0].tag);
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        exp_count = exp_count + 16'd1;
                    end
                end
            end
        end
    end

    // Presents one command and returns #1 after its accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back(model(a, b, op, tag));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", cmd_ready, 1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        if (i == 3000) begin
            check("drain_timeout_q", sb_q.size(), 0);
            check("drain_timeout_busy", busy, 0);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] held_y;
        logic [3:0] held_tag;
        int         w;

        // Reset values while held in reset.
        cycles(3);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_oe", alu_oe, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_y", rsp_y, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycles(2);

        // Single command, cycle-accurate latency.
        ready_force = 1'b1;
        send(8'h05, 8'h03, 2'b01, 4'd3);
        check("lat_oe_edge0", alu_oe, 0);
        check("lat_busy", busy, 1);
        for (int e = 1; e <= SETTLE; e++) begin
            cycles(1);
            check("lat_oe_drive", alu_oe, 1);
            check("lat_rsp_early", rsp_valid, 0);
        end
        cycles(1);
        check("lat_rsp_valid", rsp_valid, 1);
        check("lat_oe_off", alu_oe, 0);
        check("single_y", rsp_y, 8'h08);
        check("single_flags", rsp_flags, 5'b01100);
        check("single_tag", rsp_tag, 4'd3);
        drain();
        check("alu_a_held", alu_a, 8'h05);
        check("alu_b_held", alu_b, 8'h03);
        check("idle_busy", busy, 0);

        // Overflow and equal-operand boundaries.
        send(8'hFF, 8'h01, 2'b10, 4'd7);
        w = 0;
        while (!rsp_valid && w < 50) begin cycles(1); w++; end
        check("ovf_y", rsp_y, 8'h00);
        check("ovf_flags", rsp_flags, 5'b10100);
        drain();
        send(8'h5A, 8'h5A, 2'b11, 4'd9);
        w = 0;
        while (!rsp_valid && w < 50) begin cycles(1); w++; end
        check("eq_flag", rsp_flags[1], 1);
        check("eq_gt_flag", rsp_flags[2], 0);
        check("eq_lt_flag", rsp_flags[0], 0);
        drain();

        // Backpressure: hold the response, fill the buffer, verify refusal and stability.
        ready_force = 1'b0;
        cycles(1);
        send(8'h10, 8'h20, 2'b00, 4'd1);
        send(8'h30, 8'h40, 2'b01, 4'd2);
        send(8'h80, 8'h90, 2'b10, 4'd3);
        w = 0;
        while (!rsp_valid && w < 50) begin cycles(1); w++; end
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_cmd_ready_full", cmd_ready, 0);
        check("bp_busy", busy, 1);
        held_y   = rsp_y;
        held_tag = rsp_tag;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_y", rsp_y, held_y);
            check("bp_hold_tag", rsp_tag, held_tag);
            check("bp_refuse", cmd_ready, 0);
        end
        ready_force = 1'b1;
        drain();

        // Randomized traffic with random consumer backpressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send(8'($urandom), 8'($urandom), 2'($urandom), TAG_W'($urandom));
            cycles($urandom_range(0, 3));
        end
        rand_ready_en = 1'b0;
        ready_force   = 1'b1;
        drain();

        // Asynchronous reset in the middle of the drive window.
        send(8'h11, 8'h22, 2'b01, 4'd5);
        w = 0;
        while (!alu_oe && w < 20) begin cycles(1); w++; end
        check("mid_drive_oe", alu_oe, 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_count = '0;
        check("async_oe", alu_oe, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_cmd_ready", cmd_ready, 1);
        check("async_busy", busy, 0);
        check("async_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        send(8'h21, 8'h12, 2'b00, 4'd6);
        drain();
        check("post_rst_count", op_count, 1);

        // Counter wrap: preload 0xFFFF, one more handshake must wrap to zero.
        force dut.r_op_count = 16'hFFFF;
        exp_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        cycles(1);
        check("wrap_preload", op_count, 16'hFFFF);
        send(8'h01, 8'h02, 2'b00, 4'd15);
        drain();
        check("wrap_zero", op_count, 16'h0000);

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $finish;
    end

endmodule
